// File: rtl/perf_cache_pkg.sv
// rtl/perf_cache_pkg.sv - shared types for the cache perf counter collector
package perf_cache_pkg;

    localparam int PERF_CACHE_NUM_CTRS = 8;

    typedef enum logic [2:0] {
        READS        = 3'd0,
        WRITES       = 3'd1,
        READ_MISSES  = 3'd2,
        WRITE_MISSES = 3'd3,
        BANK_STALLS  = 3'd4,
        MSHR_STALLS  = 3'd5,
        MEM_STALLS   = 3'd6,
        CRSP_STALLS  = 3'd7
    } perf_ctr_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RSP  = 2'd2
    } state_e;

endpackage

// File: rtl/perf_ctr_mux.sv
// rtl/perf_ctr_mux.sv - selects counter ctr_id of cache idx; 0 for an out-of-range id
module perf_ctr_mux #(
    parameter int NUM_CACHES = 4,
    parameter int CTR_W      = 44,
    parameter int NUM_CTRS   = 8,
    parameter int ID_W       = 3,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_CACHES*NUM_CTRS*CTR_W-1:0] ctrs_in,
    input  logic [IDX_W-1:0]                     idx,
    input  logic [ID_W-1:0]                      ctr_id,
    output logic [CTR_W-1:0]                     ctr_sel
);

    always_comb begin
        ctr_sel = '0;
        for (int c = 0; c < NUM_CACHES; c++) begin
            for (int k = 0; k < NUM_CTRS; k++) begin
                if (idx == IDX_W'(c) && ctr_id == ID_W'(k)) begin
                    ctr_sel = ctrs_in[(c*NUM_CTRS+k)*CTR_W +: CTR_W];
                end
            end
        end
    end

endmodule

// File: rtl/perf_cache_collector.sv
// rtl/perf_cache_collector.sv - serial per-cache counter summation; PERF_CACHE_COLLECT_SAT_EN enables saturation
module perf_cache_collector
    import perf_cache_pkg::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int CTR_W      = 44,
    parameter int NUM_CTRS   = PERF_CACHE_NUM_CTRS,
    parameter int ID_W       = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CACHES*NUM_CTRS*CTR_W-1:0] ctrs_in,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ID_W-1:0]                      req_ctr_id,
    input  logic [NUM_CACHES-1:0]                req_mask,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [CTR_W-1:0]                     rsp_data,
    output logic                                 rsp_sat
);

    localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    state_e                state, state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [ID_W-1:0]       ctr_id_q;
    logic [NUM_CACHES-1:0] mask_q;
    logic [CTR_W-1:0]      acc, acc_add, ctr_sel;
    logic                  rsp_valid_q;
    logic                  add_en;
    logic                  last_idx;

    perf_ctr_mux #(
        .NUM_CACHES (NUM_CACHES),
        .CTR_W      (CTR_W),
        .NUM_CTRS   (NUM_CTRS),
        .ID_W       (ID_W),
        .IDX_W      (IDX_W)
    ) u_mux (
        .ctrs_in (ctrs_in),
        .idx     (idx),
        .ctr_id  (ctr_id_q),
        .ctr_sel (ctr_sel)
    );

    assign last_idx = (idx == IDX_W'(NUM_CACHES - 1));

    // Loop form keeps the mask lookup in range even when NUM_CACHES is not a power of two.
    always_comb begin
        add_en = 1'b0;
        for (int c = 0; c < NUM_CACHES; c++) begin
            if (idx == IDX_W'(c)) add_en = mask_q[c];
        end
    end

`ifdef PERF_CACHE_COLLECT_SAT_EN
    logic [CTR_W:0] sum_ext;
    logic           sat_q;

    assign sum_ext = {1'b0, acc} + {1'b0, ctr_sel};
    assign acc_add = sum_ext[CTR_W] ? {CTR_W{1'b1}} : sum_ext[CTR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            sat_q <= 1'b0;
        end else if (state == SCAN && add_en && sum_ext[CTR_W]) begin
            sat_q <= 1'b1;
        end
    end

    assign rsp_sat = rsp_valid_q & sat_q;
`else
    assign acc_add = acc + ctr_sel;
    assign rsp_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = SCAN;
            SCAN:    if (last_idx) state_nxt = RSP;
            RSP:     if (rsp_valid_q && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rsp_valid is registered one cycle after entering RSP, giving NUM_CACHES+1 latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            acc         <= '0;
            ctr_id_q    <= '0;
            mask_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ctr_id_q <= req_ctr_id;
                        mask_q   <= req_mask;
                        acc      <= '0;
                        idx      <= '0;
                    end
                end
                SCAN: begin
                    idx <= idx + IDX_W'(1);
                    if (add_en) acc <= acc_add;
                end
                RSP: begin
                    if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
                    else                          rsp_valid_q <= 1'b1;
                end
                default: rsp_valid_q <= 1'b0;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_valid_q ? acc : '0;

endmodule
